// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data memory.
//   mem_type_e : funct3 access codes (LB..LWU, 7 is invalid)
//   fsm_e      : request-side FSM states
//   size_of    : access size in bytes (0 for the invalid code)
//   is_legal   : type legality for a given word width
//   byte_en    : lane mask over a two-word window, shifted by byte offset
//   load_ext   : sign/zero extension of an LSB-aligned load
package dmem_pkg;

  typedef enum logic [2:0] {
    LB   = 3'd0,
    LH   = 3'd1,
    LW   = 3'd2,
    LD   = 3'd3,
    LBU  = 3'd4,
    LHU  = 3'd5,
    LWU  = 3'd6,
    LINV = 3'd7
  } mem_type_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } fsm_e;

  function automatic logic [3:0] size_of(input logic [2:0] t);
    return (t == LINV) ? 4'd0 : (4'd1 << t[1:0]);
  endfunction

  function automatic logic is_legal(input logic [2:0] t, input int dw);
    return (t != LINV) && !((dw == 32) && ((t == LD) || (t == LWU)));
  endfunction

  // Mask spans two words so an access crossing the word boundary spills
  // into the upper half.
  function automatic logic [15:0] byte_en(input logic [3:0] size, input logic [3:0] off);
    return ((16'd1 << size) - 16'd1) << off;
  endfunction

  function automatic logic [63:0] load_ext(input logic [63:0] raw, input logic [2:0] t);
    case (t)
      LB:      return {{56{raw[7]}}, raw[7:0]};
      LH:      return {{48{raw[15]}}, raw[15:0]};
      LW:      return {{32{raw[31]}}, raw[31:0]};
      LBU:     return {56'd0, raw[7:0]};
      LHU:     return {48'd0, raw[15:0]};
      LWU:     return {32'd0, raw[31:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-lane writable synchronous RAM, one read/write port.
//   clk   : clock
//   we    : per-lane write enable
//   addr  : word address
//   wdata : write data, lane i = wdata[8i+7:8i]
//   rdata : registered read of addr (old contents on a same-cycle write)
// Contents are not reset.
module dmem_bank #(
  parameter int NBYTES = 4,
  parameter int AWIDTH = 10
) (
  input  logic                  clk,
  input  logic [NBYTES-1:0]     we,
  input  logic [AWIDTH-1:0]     addr,
  input  logic [8*NBYTES-1:0]   wdata,
  output logic [8*NBYTES-1:0]   rdata
);

  logic [8*NBYTES-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_hs.sv
// Synchronous-read byte-lane data memory behind a valid/ready handshake.
//   clk, rst   : clock, async active-high reset
//   req_valid  : request present; accepted when req_valid && req_ready
//   req_ready  : request can be accepted this cycle
//   MemRW      : 1 store, 0 load
//   Addr       : byte address (upper bits ignored, wraps modulo depth)
//   DataW      : store data, LSB-aligned
//   req_type   : funct3 access type (see dmem_pkg::mem_type_e)
//   rsp_valid  : one-cycle pulse per accepted load, RESP_LAT after accept
//   DataR      : extended load data (0 on a faulting load)
//   err        : pulses in the response slot of a faulting access
// Optional build macro DMEM_MISALIGN_SPLIT_EN: word-crossing misaligned
// accesses are split into two beats (one stall cycle) instead of faulting.
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 10,
  parameter int RESP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRW,
  input  logic [31:0]       Addr,
  input  logic [DWIDTH-1:0] DataW,
  input  logic [2:0]        req_type,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] DataR,
  output logic              err
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int OFFW   = $clog2(NBYTES);

  logic [OFFW-1:0]     off;
  logic [AWIDTH-1:0]   widx;
  logic [3:0]          size;
  logic                legal, misal, fault;
  logic [15:0]         be_full;
  logic [2*NBYTES-1:0] be;
  logic [2*DWIDTH-1:0] wshift;

  assign off     = Addr[OFFW-1:0];
  assign widx    = Addr[AWIDTH+OFFW-1:OFFW];
  assign size    = size_of(req_type);
  assign legal   = is_legal(req_type, DWIDTH) && !(MemRW && req_type[2]);
  assign misal   = (4'(off) & (size - 4'd1)) != 4'd0;
  assign be_full = byte_en(size, 4'(off));
  assign be      = be_full[2*NBYTES-1:0];
  assign wshift  = {{DWIDTH{1'b0}}, DataW} << {off, 3'b000};

  logic                accept;
  logic [AWIDTH-1:0]   b_addr;
  logic [NBYTES-1:0]   b_we;
  logic [DWIDTH-1:0]   b_wdata, rdata;

  // "fin" marks the cycle in which an access completes its last beat.
  logic                fin, fin_load, fin_err, fin_split;
  logic [2:0]          fin_type;
  logic [OFFW-1:0]     fin_off;

`ifdef DMEM_MISALIGN_SPLIT_EN
  fsm_e                state, state_nxt;
  logic                cross, split, second;
  logic                pend_load;
  logic [2:0]          pend_type;
  logic [OFFW-1:0]     pend_off;
  logic [AWIDTH-1:0]   pend_idx;
  logic [NBYTES-1:0]   pend_be;
  logic [DWIDTH-1:0]   pend_wdata;

  assign cross = (5'(off) + 5'(size)) > 5'(NBYTES);
  assign fault = !legal;
  assign split = legal && cross;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    second    = 1'b0;
    b_addr    = widx;
    b_we      = '0;
    b_wdata   = wshift[DWIDTH-1:0];
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (MemRW && !fault) b_we = be[NBYTES-1:0];
          if (split) state_nxt = SPLIT;
        end
      end
      SPLIT: begin
        second    = 1'b1;
        b_addr    = pend_idx + AWIDTH'(1);
        b_wdata   = pend_wdata;
        b_we      = pend_load ? '0 : pend_be;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_load  <= 1'b0;
      pend_type  <= '0;
      pend_off   <= '0;
      pend_idx   <= '0;
      pend_be    <= '0;
      pend_wdata <= '0;
    end else if (accept && split) begin
      pend_load  <= !MemRW;
      pend_type  <= req_type;
      pend_off   <= off;
      pend_idx   <= widx;
      pend_be    <= be[2*NBYTES-1:NBYTES];
      pend_wdata <= wshift[2*DWIDTH-1:DWIDTH];
    end
  end

  assign fin       = (accept && !split) || second;
  assign fin_load  = second ? pend_load : !MemRW;
  assign fin_err   = second ? 1'b0 : fault;
  assign fin_type  = second ? pend_type : req_type;
  assign fin_off   = second ? pend_off : off;
  assign fin_split = second;
`else
  assign fault     = !legal || misal;
  assign req_ready = 1'b1;
  assign accept    = req_valid;
  assign b_addr    = widx;
  assign b_wdata   = wshift[DWIDTH-1:0];
  assign b_we      = (accept && MemRW && !fault) ? be[NBYTES-1:0] : '0;

  assign fin       = accept;
  assign fin_load  = !MemRW;
  assign fin_err   = fault;
  assign fin_type  = req_type;
  assign fin_off   = off;
  assign fin_split = 1'b0;
`endif

  dmem_bank #(.NBYTES(NBYTES), .AWIDTH(AWIDTH)) u_bank (
    .clk   (clk),
    .we    (b_we),
    .addr  (b_addr),
    .wdata (b_wdata),
    .rdata (rdata)
  );

  logic              s1_rsp, s1_err, s1_split;
  logic [2:0]        s1_type;
  logic [OFFW-1:0]   s1_off;
  logic [DWIDTH-1:0] hold_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_rsp   <= 1'b0;
      s1_err   <= 1'b0;
      s1_split <= 1'b0;
      s1_type  <= '0;
      s1_off   <= '0;
      hold_lo  <= '0;
    end else begin
      s1_rsp   <= fin && fin_load;
      s1_err   <= fin && fin_err;
      s1_split <= fin && fin_split;
      if (fin) begin
        s1_type <= fin_type;
        s1_off  <= fin_off;
      end
      // During the second beat the bank output still holds word W.
      if (fin_split) hold_lo <= rdata;
    end
  end

  logic [2*DWIDTH-1:0] pair, shifted;
  logic [63:0]         ext;
  logic [DWIDTH-1:0]   data1;

  assign pair    = s1_split ? {rdata, hold_lo} : {{DWIDTH{1'b0}}, rdata};
  assign shifted = pair >> {s1_off, 3'b000};
  assign ext     = load_ext(64'(shifted[DWIDTH-1:0]), s1_type);
  assign data1   = (s1_rsp && !s1_err) ? ext[DWIDTH-1:0] : '0;

  generate
    if (RESP_LAT == 2) begin : g_lat2
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rsp_valid <= 1'b0;
          err       <= 1'b0;
          DataR     <= '0;
        end else begin
          rsp_valid <= s1_rsp;
          err       <= s1_err;
          DataR     <= data1;
        end
      end
    end else begin : g_lat1
      assign rsp_valid = s1_rsp;
      assign err       = s1_err;
      assign DataR     = data1;
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{Addr, be_full, wshift, ext, shifted, misal};

endmodule

// File: tb/tb_data_memory_hs.sv
module tb_data_memory_hs;

  localparam int AW  = 4;
  localparam int TOT = 4 * (2 ** AW);
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        MemRW = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] DataW = '0;
  logic [2:0]  req_type = '0;
  logic        rdy1, rv1, er1, rdy2, rv2, er2;
  logic [31:0] dr1, dr2;

  always #5 clk = ~clk;

  data_memory_hs #(.DWIDTH(32), .AWIDTH(AW), .RESP_LAT(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .MemRW(MemRW),
    .Addr(Addr), .DataW(DataW), .req_type(req_type), .rsp_valid(rv1), .DataR(dr1), .err(er1));

  data_memory_hs #(.DWIDTH(32), .AWIDTH(AW), .RESP_LAT(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .MemRW(MemRW),
    .Addr(Addr), .DataW(DataW), .req_type(req_type), .rsp_valid(rv2), .DataR(dr2), .err(er2));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference: flat byte array, expected outputs per cycle slot.
  logic [7:0]  mmem [0:TOT-1];
  logic        ev [0:1][0:7];
  logic        ee [0:1][0:7];
  logic [31:0] ed [0:1][0:7];
  logic        exp_ready = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic clear_slots();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 8; s++) begin
        ev[d][s] = 1'b0;
        ee[d][s] = 1'b0;
        ed[d][s] = '0;
      end
  endtask

  always @(negedge clk) begin
    int s;
    s = cyc % 8;
    check("ready_lat1", {31'd0, rdy1}, {31'd0, exp_ready});
    check("ready_lat2", {31'd0, rdy2}, {31'd0, exp_ready});
    check("rsp_valid_lat1", {31'd0, rv1}, {31'd0, ev[0][s]});
    check("rsp_valid_lat2", {31'd0, rv2}, {31'd0, ev[1][s]});
    check("err_lat1", {31'd0, er1}, {31'd0, ee[0][s]});
    check("err_lat2", {31'd0, er2}, {31'd0, ee[1][s]});
    if (ev[0][s]) check("data_lat1", dr1, ed[0][s]);
    if (ev[1][s]) check("data_lat2", dr2, ed[1][s]);
    if (rst) begin
      check("data_rst_lat1", dr1, 32'd0);
      check("data_rst_lat2", dr2, 32'd0);
    end
    for (int d = 0; d < 2; d++) begin
      ev[d][s] = 1'b0;
      ee[d][s] = 1'b0;
    end
  end

  // Applies one accepted access to the reference and schedules its response.
  task automatic model_acc(input logic st, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] t, output logic [31:0] mv,
                           output logic me, output logic ex);
    int sz, off, base;
    logic legal, mis;
    logic [63:0] v;
    sz    = 1 << t[1:0];
    off   = int'(a % 4);
    base  = int'(a % TOT);
    legal = (t != 3'd7) && (t != 3'd3) && (t != 3'd6) && !(st && t >= 3'd4);
    mis   = (off % sz) != 0;
    me    = !legal || (mis && !SPLIT_EN);
    ex    = SPLIT_EN && legal && (off + sz > 4);
    v     = '0;
    if (!me)
      for (int k = 0; k < sz; k++) begin
        if (st) mmem[(base + k) % TOT] = d[8*k +: 8];
        else    v[8*k +: 8] = mmem[(base + k) % TOT];
      end
    if (!st && !me && t < 3'd4 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
    mv = v[31:0];
    if (!st || me)
      for (int l = 0; l < 2; l++) begin
        int s;
        s = (cyc + int'(ex) + l) % 8;
        ev[l][s] = !st;
        ee[l][s] = me;
        ed[l][s] = mv;
      end
  endtask

  task automatic issue(input logic st, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] t, output logic [31:0] mv, output logic me);
    logic ex;
    int tries;
    tries = 0;
    mv = '0;
    me = 1'b0;
    req_valid = 1'b1; MemRW = st; Addr = a; DataW = d; req_type = t;
    forever begin
      @(posedge clk); #1;
      if (exp_ready) begin
        model_acc(st, a, d, t, mv, me, ex);
        exp_ready = !ex;
        break;
      end
      exp_ready = 1'b1;
      tries++;
      if (tries > 3) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      exp_ready = 1'b1;
    end
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    #1;
    clear_slots();
    exp_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mv;
    logic        me;
    clear_slots();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int w = 0; w < TOT / 4; w++) issue(1'b1, 32'(4 * w), $urandom, 3'd2, mv, me);

    issue(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, mv, me);
    issue(1'b0, 32'h10, 32'h0, 3'd2, mv, me);
    check("pin_lw", mv, 32'hDEADBEEF);
    check("pin_lw_err", {31'd0, me}, 32'd0);
    issue(1'b0, 32'h11, 32'h0, 3'd0, mv, me); check("pin_lb", mv, 32'hFFFFFFBE);
    issue(1'b0, 32'h11, 32'h0, 3'd4, mv, me); check("pin_lbu", mv, 32'h000000BE);
    issue(1'b0, 32'h12, 32'h0, 3'd1, mv, me); check("pin_lh", mv, 32'hFFFFDEAD);
    issue(1'b0, 32'h12, 32'h0, 3'd5, mv, me); check("pin_lhu", mv, 32'h0000DEAD);
    issue(1'b1, 32'h13, 32'h55, 3'd0, mv, me);
    issue(1'b0, 32'h10, 32'h0, 3'd2, mv, me); check("pin_sb_lw", mv, 32'h55ADBEEF);
    issue(1'b0, 32'h10, 32'h0, 3'd7, mv, me);
    check("pin_t7_err", {31'd0, me}, 32'd1);
    check("pin_t7_data", mv, 32'd0);
    issue(1'b1, 32'h10, 32'h12345678, 3'd3, mv, me);
    check("pin_sd32_err", {31'd0, me}, 32'd1);
`ifndef DMEM_MISALIGN_SPLIT_EN
    issue(1'b1, 32'h11, 32'h0000BBBB, 3'd1, mv, me);
    check("pin_sh_mis_err", {31'd0, me}, 32'd1);
`endif
    issue(1'b0, 32'h10, 32'h0, 3'd2, mv, me); check("pin_unchanged", mv, 32'h55ADBEEF);
    issue(1'b1, 32'(TOT), 32'hA5A5A5A5, 3'd2, mv, me);
    issue(1'b0, 32'h0, 32'h0, 3'd2, mv, me); check("pin_wrap", mv, 32'hA5A5A5A5);

`ifdef DMEM_MISALIGN_SPLIT_EN
    issue(1'b1, 32'h0E, 32'h11223344, 3'd2, mv, me);
    issue(1'b0, 32'h0E, 32'h0, 3'd2, mv, me); check("pin_split_lw", mv, 32'h11223344);
    issue(1'b0, 32'h0C, 32'h0, 3'd2, mv, me); check("pin_split_hi", {16'd0, mv[31:16]}, 32'h3344);
    issue(1'b0, 32'h1E, 32'h0, 3'd2, mv, me);
    do_reset();
    issue(1'b1, 32'h30, 32'h0, 3'd2, mv, me);
    issue(1'b1, 32'h2E, 32'hCAFEF00D, 3'd2, mv, me);
    do_reset();
    mmem[8'h30] = 8'h00;
    mmem[8'h31] = 8'h00;
    issue(1'b0, 32'h30, 32'h0, 3'd2, mv, me); check("pin_partial_hi", mv, 32'h0);
    issue(1'b0, 32'h2C, 32'h0, 3'd2, mv, me); check("pin_partial_lo", {16'd0, mv[31:16]}, 32'hF00D);
`endif

    issue(1'b0, 32'h10, 32'h0, 3'd2, mv, me);
    do_reset();

    for (int i = 0; i < 600; i++) begin
      issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
            3'($urandom_range(0, 7)), mv, me);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
      if (i == 300) do_reset();
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
